// File: rtl/masked_hpc4_rand_gen.sv
// HPC4 mask-bundle generator: NUM_LANES unrolled 32-bit Galois LFSRs behind a valid/ready handshake.
// Define MASKED_RAND_HEALTH_EN to add the sticky lane health monitor driving out_error.
module masked_hpc4_rand_gen #(
  parameter int NUM_SHARES   = 2,
  parameter int BIT_WIDTH    = 4,
  parameter int WARMUP_BEATS = 16,
  localparam int NQW = (NUM_SHARES * (NUM_SHARES - 1) / 2) * BIT_WIDTH
) (
  input  logic           in_clock,
  input  logic           in_reset,
  input  logic           in_seed_valid,
  input  logic [31:0]    in_seed,
  output logic           out_seed_ready,
  output logic           out_valid,
  input  logic           in_ready,
  output logic [NQW-1:0] out_r0a,
  output logic [NQW-1:0] out_r0b,
  output logic [NQW-1:0] out_r1,
  output logic [NQW-1:0] out_r2,
  output logic [NQW-1:0] out_r3,
  output logic           out_error
);

  localparam int TOTAL     = 5 * NQW;
  localparam int NUM_LANES = (TOTAL + 31) / 32;
  localparam int CNT_W     = $clog2(NUM_LANES + 1);
  localparam int WARM_W    = (WARMUP_BEATS > 0) ? $clog2(WARMUP_BEATS + 1) : 1;
  localparam logic [31:0] POLY   = 32'h80200003;
  localparam logic [31:0] GOLDEN = 32'h9E3779B9;
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(NUM_LANES);

  typedef enum logic [1:0] {IDLE, SEED, WARMUP, RUN} state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           lane_cnt_q, lane_cnt_d;
  logic [WARM_W-1:0]          warm_cnt_q, warm_cnt_d;
  logic [NUM_LANES-1:0][31:0] lane_q, lane_d;
  logic [TOTAL-1:0]           lane_bits;
  logic [TOTAL-1:0]           bundle;
  logic                       seed_hs;
  logic                       accept;
  logic                       advance;

  function automatic logic [31:0] lfsr_beat(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < 32; i++) begin
      v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
    end
    return v;
  endfunction

  // An all-zero load would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] seed_word(input logic [31:0] seed, input int k);
    logic [31:0] v;
    v = seed ^ (GOLDEN * 32'(k + 1));
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

  assign out_seed_ready = (state_q == IDLE) || (state_q == SEED) || (state_q == RUN);
  assign seed_hs        = in_seed_valid && out_seed_ready;
  assign out_valid      = (state_q == RUN) && !seed_hs;
  assign accept         = out_valid && in_ready;
  assign advance        = (state_q == WARMUP) || accept;

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    warm_cnt_d = warm_cnt_q;
    lane_d     = lane_q;
    if (advance) begin
      for (int k = 0; k < NUM_LANES; k++) lane_d[k] = lfsr_beat(lane_q[k]);
    end
    case (state_q)
      IDLE, RUN: begin
        if (seed_hs) begin
          lane_d[0]  = seed_word(in_seed, 0);
          lane_cnt_d = CNT_W'(1);
          state_d    = SEED;
        end
      end
      SEED: begin
        if (lane_cnt_q == LANES_C) begin
          warm_cnt_d = '0;
          state_d    = (WARMUP_BEATS == 0) ? RUN : WARMUP;
        end else if (in_seed_valid) begin
          for (int k = 0; k < NUM_LANES; k++) begin
            if (lane_cnt_q == CNT_W'(k)) lane_d[k] = seed_word(in_seed, k);
          end
          lane_cnt_d = lane_cnt_q + CNT_W'(1);
        end
      end
      WARMUP: begin
        if (warm_cnt_q != WARM_W'(WARMUP_BEATS)) warm_cnt_d = warm_cnt_q + WARM_W'(1);
        if (warm_cnt_q == WARM_W'(WARMUP_BEATS - 1)) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      warm_cnt_q <= '0;
      lane_q     <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      lane_q     <= lane_d;
    end
  end

  // Lane 0 fills the LSBs; bits of the last lane beyond TOTAL are dropped.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam int LO = k * 32;
    localparam int HI = (LO + 32 > TOTAL) ? TOTAL : LO + 32;
    assign lane_bits[HI-1:LO] = lane_q[k][HI-LO-1:0];
  end

  assign bundle  = (state_q == IDLE) ? '0 : lane_bits;
  assign out_r0a = bundle[0*NQW +: NQW];
  assign out_r0b = bundle[1*NQW +: NQW];
  assign out_r1  = bundle[2*NQW +: NQW];
  assign out_r2  = bundle[3*NQW +: NQW];
  assign out_r3  = bundle[4*NQW +: NQW];

`ifdef MASKED_RAND_HEALTH_EN
  logic [NUM_LANES-1:0][31:0] hist_q, hist_d;
  logic                       error_q, error_d;

  always_comb begin
    hist_d  = hist_q;
    error_d = error_q;
    if (state_d == SEED && state_q != SEED) hist_d = '0;
    else if (accept) hist_d = lane_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (state_q == RUN && lane_q[k] == 32'h0) error_d = 1'b1;
      if (accept && lane_q[k] == hist_q[k]) error_d = 1'b1;
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      hist_q  <= '0;
      error_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      error_q <= error_d;
    end
  end

  assign out_error = error_q;
`else
  assign out_error = 1'b0;
`endif

endmodule

// File: tb/tb_masked_hpc4_rand_gen.sv
// Scoreboard bench for masked_hpc4_rand_gen: a 1-lane instance (defaults) and a 2-lane instance (NUM_SHARES=3).
// Expected bundles come from a Galois LFSR reference model and are popped by per-instance monitors.
module tb_masked_hpc4_rand_gen;

  localparam logic [31:0] POLY   = 32'h80200003;
  localparam logic [31:0] GOLDEN = 32'h9E3779B9;
  localparam int WARM    = 16;
  localparam int TOTAL_A = 20;
  localparam int TOTAL_B = 60;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic        seedValidA = 1'b0, readyA = 1'b0;
  logic [31:0] seedA = '0;
  logic        seedReadyA, validA, errorA;
  logic [3:0]  r0aA, r0bA, r1A, r2A, r3A;
  logic        seedValidB = 1'b0, readyB = 1'b0;
  logic [31:0] seedB = '0;
  logic        seedReadyB, validB, errorB;
  logic [11:0] r0aB, r0bB, r1B, r2B, r3B;

  int checks = 0;
  int errors = 0;
  logic [63:0] qA[$];
  logic [63:0] qB[$];
  bit monA = 1'b1;
  bit monB = 1'b1;
  logic [31:0] mdlA, mdlB0, mdlB1;

  masked_hpc4_rand_gen dutA (
    .in_clock(clock), .in_reset(reset), .in_seed_valid(seedValidA), .in_seed(seedA),
    .out_seed_ready(seedReadyA), .out_valid(validA), .in_ready(readyA),
    .out_r0a(r0aA), .out_r0b(r0bA), .out_r1(r1A), .out_r2(r2A), .out_r3(r3A),
    .out_error(errorA)
  );

  masked_hpc4_rand_gen #(.NUM_SHARES(3), .BIT_WIDTH(4), .WARMUP_BEATS(WARM)) dutB (
    .in_clock(clock), .in_reset(reset), .in_seed_valid(seedValidB), .in_seed(seedB),
    .out_seed_ready(seedReadyB), .out_valid(validB), .in_ready(readyB),
    .out_r0a(r0aB), .out_r0b(r0bB), .out_r1(r1B), .out_r2(r2B), .out_r3(r3B),
    .out_error(errorB)
  );

  function automatic logic [31:0] galoisBeat(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < 32; i++) begin
      if (v[0]) v = (v >> 1) ^ POLY;
      else v = v >> 1;
    end
    return v;
  endfunction

  function automatic logic [31:0] warmUp(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < WARM; i++) v = galoisBeat(v);
    return v;
  endfunction

  function automatic logic [31:0] seedLoad(input logic [31:0] seed, input int k);
    logic [31:0] c;
    logic [31:0] v;
    c = GOLDEN * 32'(k + 1);
    v = seed ^ c;
    if (v == 32'h0) v = 32'h1;
    return v;
  endfunction

  function automatic logic [63:0] bundleOf(input logic [31:0] l0, input logic [31:0] l1, input int total);
    logic [63:0] v;
    v = {l1, l0};
    for (int i = total; i < 64; i++) v[i] = 1'b0;
    return v;
  endfunction

  function automatic logic [63:0] gotA();
    return {44'h0, r3A, r2A, r1A, r0bA, r0aA};
  endfunction

  function automatic logic [63:0] gotB();
    return {4'h0, r3B, r2B, r1B, r0bB, r0aB};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit useB, input bit sv, input logic [31:0] sd, input bit rdy);
    @(posedge clock);
    #1;
    if (useB) begin
      seedValidB = sv; seedB = sd; readyB = rdy;
    end else begin
      seedValidA = sv; seedA = sd; readyA = rdy;
    end
  endtask

  task automatic waitValid(input bit useB, input int expLat, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(posedge clock);
      #1;
      n++;
      seen = useB ? validB : validA;
    end
    checkOutput(name, 64'(n), 64'(expLat));
  endtask

  // Each ready cycle consumes the shown bundle, so its successor is queued alongside.
  task automatic runA(input int n, input bit randomReady);
    for (int i = 0; i < n; i++) begin
      bit r;
      r = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, r);
      if (r) begin
        mdlA = galoisBeat(mdlA);
        qA.push_back(bundleOf(mdlA, 32'h0, TOTAL_A));
      end
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("queueA", 64'(qA.size()), 64'd1);
  endtask

  task automatic runB(input int n, input bit randomReady);
    for (int i = 0; i < n; i++) begin
      bit r;
      r = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h0, r);
      if (r) begin
        mdlB0 = galoisBeat(mdlB0);
        mdlB1 = galoisBeat(mdlB1);
        qB.push_back(bundleOf(mdlB0, mdlB1, TOTAL_B));
      end
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("queueB", 64'(qB.size()), 64'd1);
  endtask

  always @(negedge clock) begin
    if (monA && !reset && validA) begin
      if (qA.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL bundleA: got %h expected nothing", gotA());
      end else begin
        checkOutput("bundleA", gotA(), qA[0]);
        if (readyA) void'(qA.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (monB && !reset && validB) begin
      if (qB.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL bundleB: got %h expected nothing", gotB());
      end else begin
        checkOutput("bundleB", gotB(), qB[0]);
        if (readyB) void'(qB.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not end, checks %0d errors %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] s;
    logic [31:0] w0;
    logic [31:0] w1;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    checkOutput("resetValidA", 64'(validA), 64'd0);
    checkOutput("resetSeedReadyA", 64'(seedReadyA), 64'd1);
    checkOutput("resetErrorA", 64'(errorA), 64'd0);
    checkOutput("resetBundleA", gotA(), 64'd0);
    checkOutput("resetValidB", 64'(validB), 64'd0);
    checkOutput("resetBundleB", gotB(), 64'd0);

    // Seed equal to the lane-0 constant exercises the zero substitution.
    $display("[TB] instance A: zero-substituted seed");
    applyStimulus(1'b0, 1'b1, GOLDEN, 1'b0);
    mdlA = warmUp(seedLoad(GOLDEN, 0));
    qA.push_back(bundleOf(mdlA, 32'h0, TOTAL_A));
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    waitValid(1'b0, 17, "latencyA");
    repeat (5) @(posedge clock);
    #1;
    runA(8, 1'b0);
    repeat (2) @(posedge clock);

    $display("[TB] instance A: reseed while consumer ready");
    s = $urandom;
    applyStimulus(1'b0, 1'b1, s, 1'b1);
    @(negedge clock);
    checkOutput("reseedValidDropA", 64'(validA), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    qA.delete();
    mdlA = warmUp(seedLoad(s, 0));
    qA.push_back(bundleOf(mdlA, 32'h0, TOTAL_A));
    waitValid(1'b0, 17, "reseedLatencyA");
    runA(30, 1'b1);

    $display("[TB] instance A: reset during RUN");
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("midResetValidA", 64'(validA), 64'd0);
    checkOutput("midResetSeedReadyA", 64'(seedReadyA), 64'd1);
    checkOutput("midResetBundleA", gotA(), 64'd0);
    checkOutput("midResetErrorA", 64'(errorA), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    qA.delete();

    $display("[TB] instance B: two-lane seeding with a stall");
    w0 = $urandom;
    w1 = $urandom;
    applyStimulus(1'b1, 1'b1, w0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, w1, 1'b0);
    mdlB0 = warmUp(seedLoad(w0, 0));
    mdlB1 = warmUp(seedLoad(w1, 1));
    qB.push_back(bundleOf(mdlB0, mdlB1, TOTAL_B));
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    waitValid(1'b1, 17, "latencyB");
    @(negedge clock);
    checkOutput("r3Lane1B", 64'(r3B), 64'(mdlB1[27:16]));
    #1;
    runB(6, 1'b0);
    runB(20, 1'b1);

`ifdef MASKED_RAND_HEALTH_EN
    $display("[TB] instance B: zeroed lane health fault");
    monB = 1'b0;
    @(posedge clock);
    #1 force dutB.lane_q[0] = 32'h0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("healthErrorB", 64'(errorB), 64'd1);
    checkOutput("healthValidB", 64'(validB), 64'd1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("healthStickyB", 64'(errorB), 64'd1);
    release dutB.lane_q[0];
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("healthClearB", 64'(errorB), 64'd0);
    #1 reset = 1'b0;
`else
    @(negedge clock);
    checkOutput("errorTiedB", 64'(errorB), 64'd0);
`endif

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
